xg_fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the decode stage and its controller. It issues in-order requests to the instruction memory and buffers returned instructions with their PCs in a small queue. It presents one instruction per cycle to decode through a valid/ready handshake. Redirects from jal/jalr/taken branches flush the queue and discard any responses still in flight.

---
 rtl/xg_fetch_unit_pkg.sv | 7 +
 rtl/xg_fetch_fifo.sv | 40 ++++
 rtl/xg_fetch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/xg_fetch_unit_pkg.sv
// xg_fetch_unit_pkg: shared fetch-stage constants and the run/drain state type
package xg_fetch_unit_pkg;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int XG_FETCH_DEPTH = 2;
  localparam logic [31:0] XG_RESET_PC = 32'h0000_0000;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/xg_fetch_fifo.sv
// xg_fetch_fifo: synchronous {pc,instr} queue with push, pop, flush and count
// Ports: clk/reset (sync, active-high); push with push_pc/push_instr; pop; flush
// empties the queue; count is the fill level; head_pc/head_instr show the oldest entry.
module xg_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int AW = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [AW-1:0]            push_pc,
  input  logic [31:0]              push_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [AW-1:0]            head_pc,
  output logic [31:0]              head_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW+31:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign {head_pc, head_instr} = mem[rd_ptr];
  // On a full queue with a simultaneous pop, wr_ptr equals rd_ptr: the write
  // lands in the slot being vacated, so the new entry ends up behind the head.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= {push_pc, push_instr};
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/xg_fetch_unit.sv
// xg_fetch_unit: in-order instruction fetch with credit-limited queue and redirect flush
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_gnt request side;
// imem_rvalid/imem_rdata in-order responses; redirect/redirect_pc pipeline redirect;
// id_valid/id_ready/id_instr/id_pc decode handshake.
// XG_FETCH_NOP_INJECT_EN: when defined, id_instr shows a NOP during bubbles and
// id_pc holds the last popped PC; otherwise both hold the last head values.
module xg_fetch_unit
  import xg_fetch_unit_pkg::*;
#(
  parameter int DEPTH = XG_FETCH_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(XG_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [31:0]           id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, aligned_pc, head_pc, last_pc;
  logic [31:0] head_instr;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic gnt, rv, push, pop;
  fetch_state_e state;
  assign aligned_pc = redirect_pc & ~ADDR_WIDTH'(3);
  assign state = drop_cnt != '0 ? DRAIN : RUN;
  // A response with nothing outstanding belongs to a request issued before reset.
  assign rv = imem_rvalid && outstanding != '0;
  // Credit counts in-flight requests plus queued entries, so a push never overflows.
  assign imem_req = !reset && !redirect && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign gnt = imem_req && imem_gnt;
  assign push = rv && !redirect && state == RUN;
  assign id_valid = count != '0;
  assign pop = id_valid && id_ready && !redirect;
  assign id_pc = id_valid ? head_pc : last_pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(gnt) - CW'(rv);
      if (redirect) begin
        fetch_pc <= aligned_pc;
        resp_pc  <= aligned_pc;
        drop_cnt <= outstanding - CW'(rv);
      end else begin
        if (gnt) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (push) resp_pc <= resp_pc + ADDR_WIDTH'(4);
        if (rv && state == DRAIN) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end
  xg_fetch_fifo #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_pc    (resp_pc),
    .push_instr (imem_rdata),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );
`ifdef XG_FETCH_NOP_INJECT_EN
  always_ff @(posedge clk) last_pc <= reset ? '0 : pop ? head_pc : last_pc;
  assign id_instr = id_valid ? head_instr : INSTR_NOP;
`else
  logic [31:0] last_instr;
  always_ff @(posedge clk) begin
    if (reset) {last_pc, last_instr} <= '0;
    else if (id_valid) {last_pc, last_instr} <= {head_pc, head_instr};
  end
  assign id_instr = id_valid ? head_instr : last_instr;
`endif
endmodule
